// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: pipeline hazard / branch / halt controller.
// Generates latch load enables and flush requests for a three-stage
// (Fetch, Decode, Execute) pipeline and keeps a saturating stall counter.
module pipeline_ctrl #(
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] dec_ra,
  input  logic [1:0] dec_rb,
  input  logic       dec_use_ra,
  input  logic       dec_use_rb,
  input  logic [1:0] ex_rd,
  input  logic       ex_RW,
  input  logic       ex_load,
  input  logic       ex_br_taken,
  input  logic       ex_Hlt,
  input  logic       resume,
  output logic       pc_ld,
  output logic       f_d_ld,
  output logic       d_ex_ld,
  output logic       f_d_flush,
  output logic       d_ex_flush,
  output logic       halted,
  output logic [7:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [1:0] BUB_INIT = 2'(LOAD_LAT - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_bub;
  logic [1:0] w_next_bub;
  logic [7:0] r_stall_cnt;
  logic       w_hazard;
  logic       w_stall_inc;

  logic w_pc_ld, w_f_d_ld, w_d_ex_ld, w_f_d_flush, w_d_ex_flush, w_halted;

  // Load-use hazard: Execute holds a load whose target Decode is reading.
  always_comb begin
    w_hazard = ex_load & ex_RW &
               ((dec_use_ra & (dec_ra == ex_rd)) |
                (dec_use_rb & (dec_rb == ex_rd)));
  end

  // Mealy next-state and control outputs (priority: halt > branch > hazard).
  always_comb begin
    w_next_state = r_state;
    w_next_bub   = r_bub;
    w_pc_ld      = 1'b0;
    w_f_d_ld     = 1'b0;
    w_d_ex_ld    = 1'b0;
    w_f_d_flush  = 1'b0;
    w_d_ex_flush = 1'b0;
    w_halted     = 1'b0;
    unique case (r_state)
      RUN: begin
        w_d_ex_ld = 1'b1;
        if (ex_Hlt) begin
          w_f_d_flush  = 1'b1;
          w_d_ex_flush = 1'b1;
          w_next_state = HALT;
        end else if (ex_br_taken) begin
          w_pc_ld      = 1'b1;
          w_f_d_ld     = 1'b1;
          w_f_d_flush  = 1'b1;
          w_d_ex_flush = 1'b1;
        end else if (w_hazard) begin
          w_d_ex_flush = 1'b1;
          if (LOAD_LAT > 1) begin
            w_next_state = STALL;
            w_next_bub   = BUB_INIT;
          end
        end else begin
          w_pc_ld  = 1'b1;
          w_f_d_ld = 1'b1;
        end
      end
      STALL: begin
        // Execute already holds a bubble, so branch/halt/hazard are ignored.
        w_d_ex_ld    = 1'b1;
        w_d_ex_flush = 1'b1;
        if (r_bub <= 2'd1) begin
          w_next_state = RUN;
          w_next_bub   = '0;
        end else begin
          w_next_bub = r_bub - 2'd1;
        end
      end
      HALT: begin
        w_halted = 1'b1;
        if (resume) w_next_state = RUN;
      end
      default: w_next_state = RUN;
    endcase
  end

  // Outputs are forced inactive for as long as reset is held.
  always_comb begin
    pc_ld      = reset & w_pc_ld;
    f_d_ld     = reset & w_f_d_ld;
    d_ex_ld    = reset & w_d_ex_ld;
    f_d_flush  = reset & w_f_d_flush;
    d_ex_flush = reset & w_d_ex_flush;
    halted     = reset & w_halted;
    stall_cnt  = r_stall_cnt;
  end

  // A stall cycle is any non-HALT cycle in which the PC is held.
  always_comb begin
    w_stall_inc = (r_state != HALT) && !w_pc_ld;
  end

  // State and bubble counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_bub   <= '0;
    end else begin
      r_state <= w_next_state;
      r_bub   <= w_next_bub;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall_inc && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: two instances (LOAD_LAT=1 and 3)
// share one input stream and are compared against a behavioural model.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dec_ra, dec_rb, ex_rd;
  logic       dec_use_ra, dec_use_rb, ex_RW, ex_load, ex_br_taken, ex_Hlt, resume;

  logic       a_pc, a_fd, a_dex, a_fdf, a_dexf, a_halt;
  logic       b_pc, b_fd, b_dex, b_fdf, b_dexf, b_halt;
  logic [7:0] a_cnt, b_cnt;

  logic [5:0] o_vec [2];
  logic [7:0] o_cnt [2];

  // Output vector layout: {pc_ld, f_d_ld, d_ex_ld, f_d_flush, d_ex_flush, halted}
  localparam logic [5:0] V_NORM  = 6'b111000;
  localparam logic [5:0] V_BR    = 6'b111110;
  localparam logic [5:0] V_HLT   = 6'b001110;
  localparam logic [5:0] V_STALL = 6'b001010;
  localparam logic [5:0] V_HALT  = 6'b000001;
  localparam logic [5:0] V_RST   = 6'b000000;

  int nchk = 0;
  int nerr = 0;

  // Model state: stall cycles still owed, halted flag, stall count.
  int rem [2];
  bit hlt [2];
  int cnt [2];
  int lat [2] = '{1, 3};

  always #5 clk = ~clk;

  pipeline_ctrl #(.LOAD_LAT(1)) u_a (
    .clk(clk), .reset(reset), .dec_ra(dec_ra), .dec_rb(dec_rb),
    .dec_use_ra(dec_use_ra), .dec_use_rb(dec_use_rb), .ex_rd(ex_rd),
    .ex_RW(ex_RW), .ex_load(ex_load), .ex_br_taken(ex_br_taken),
    .ex_Hlt(ex_Hlt), .resume(resume), .pc_ld(a_pc), .f_d_ld(a_fd),
    .d_ex_ld(a_dex), .f_d_flush(a_fdf), .d_ex_flush(a_dexf),
    .halted(a_halt), .stall_cnt(a_cnt));

  pipeline_ctrl #(.LOAD_LAT(3)) u_b (
    .clk(clk), .reset(reset), .dec_ra(dec_ra), .dec_rb(dec_rb),
    .dec_use_ra(dec_use_ra), .dec_use_rb(dec_use_rb), .ex_rd(ex_rd),
    .ex_RW(ex_RW), .ex_load(ex_load), .ex_br_taken(ex_br_taken),
    .ex_Hlt(ex_Hlt), .resume(resume), .pc_ld(b_pc), .f_d_ld(b_fd),
    .d_ex_ld(b_dex), .f_d_flush(b_fdf), .d_ex_flush(b_dexf),
    .halted(b_halt), .stall_cnt(b_cnt));

  assign o_vec[0] = {a_pc, a_fd, a_dex, a_fdf, a_dexf, a_halt};
  assign o_vec[1] = {b_pc, b_fd, b_dex, b_fdf, b_dexf, b_halt};
  assign o_cnt[0] = a_cnt;
  assign o_cnt[1] = b_cnt;

  function automatic bit hz();
    return ex_load && ex_RW &&
           ((dec_use_ra && dec_ra == ex_rd) || (dec_use_rb && dec_rb == ex_rd));
  endfunction

  function automatic logic [5:0] exp_vec(int k);
    if (!reset)      return V_RST;
    if (hlt[k])      return V_HALT;
    if (rem[k] > 0)  return V_STALL;
    if (ex_Hlt)      return V_HLT;
    if (ex_br_taken) return V_BR;
    if (hz())        return V_STALL;
    return V_NORM;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; hlt[k] = 0; cnt[k] = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both DUTs against the model on the falling edge.
  task automatic cyc();
    @(negedge clk);
    if (!reset) model_clear();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("outs_%0d(vec)", k), int'(o_vec[k]), int'(exp_vec(k)));
      chk($sformatf("stall_cnt_%0d", k), int'(o_cnt[k]), cnt[k]);
    end
  endtask

  // Advance the model across the rising edge using pre-edge inputs.
  task automatic adv();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        rem[k] = 0; hlt[k] = 0; cnt[k] = 0;
      end else if (hlt[k]) begin
        if (resume) hlt[k] = 0;
      end else begin
        if (rem[k] > 0) begin
          rem[k]--;
          cnt[k] = (cnt[k] < 255) ? cnt[k] + 1 : 255;
        end else if (ex_Hlt) begin
          hlt[k] = 1;
          cnt[k] = (cnt[k] < 255) ? cnt[k] + 1 : 255;
        end else if (!ex_br_taken && hz()) begin
          rem[k] = lat[k] - 1;
          cnt[k] = (cnt[k] < 255) ? cnt[k] + 1 : 255;
        end
      end
    end
    #1;
  endtask

  task automatic tick();
    cyc();
    adv();
  endtask

  task automatic idle();
    dec_ra = 2'd0; dec_rb = 2'd0; ex_rd = 2'd0;
    dec_use_ra = 0; dec_use_rb = 0; ex_RW = 0; ex_load = 0;
    ex_br_taken = 0; ex_Hlt = 0; resume = 0;
  endtask

  task automatic set_hazard();
    idle();
    ex_load = 1; ex_RW = 1; ex_rd = 2'd2; dec_ra = 2'd2; dec_use_ra = 1;
    dec_rb = 2'd1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    model_clear();
    #1;
    chk("rst_vec_a", int'(o_vec[0]), int'(V_RST));
    chk("rst_vec_b", int'(o_vec[1]), int'(V_RST));
    tick();
    reset = 1'b1;

    // Single load-use hazard; branch in the second cycle.
    set_hazard();
    cyc();
    chk("hz_a", int'(o_vec[0]), int'(V_STALL));
    chk("hz_b", int'(o_vec[1]), int'(V_STALL));
    adv();
    idle(); ex_br_taken = 1;
    cyc();
    chk("hz_next_a_br", int'(o_vec[0]), int'(V_BR));
    chk("hz_cnt_a", int'(o_cnt[0]), 1);
    chk("stall2_b_br_ignored", int'(o_vec[1]), int'(V_STALL));
    chk("stall2_cnt_b", int'(o_cnt[1]), 1);
    adv();
    idle();
    cyc();
    chk("stall3_b", int'(o_vec[1]), int'(V_STALL));
    chk("stall3_cnt_b", int'(o_cnt[1]), 2);
    chk("idle_a", int'(o_vec[0]), int'(V_NORM));
    adv();
    cyc();
    chk("stall_done_b", int'(o_vec[1]), int'(V_NORM));
    chk("stall_total_b", int'(o_cnt[1]), 3);
    chk("cnt_a_kept", int'(o_cnt[0]), 1);
    adv();

    // Branch beats a concurrent hazard.
    set_hazard(); ex_br_taken = 1;
    cyc();
    chk("br_hz_a", int'(o_vec[0]), int'(V_BR));
    chk("br_hz_b", int'(o_vec[1]), int'(V_BR));
    adv();
    idle();
    cyc();
    chk("br_hz_next_b", int'(o_vec[1]), int'(V_NORM));
    chk("br_hz_cnt_a", int'(o_cnt[0]), 1);
    chk("br_hz_cnt_b", int'(o_cnt[1]), 3);
    adv();

    // Halt beats branch; idle in HALT; resume.
    ex_Hlt = 1; ex_br_taken = 1;
    cyc();
    chk("hlt_a", int'(o_vec[0]), int'(V_HLT));
    chk("hlt_b", int'(o_vec[1]), int'(V_HLT));
    adv();
    idle();
    cyc();
    chk("halted_a", int'(o_vec[0]), int'(V_HALT));
    chk("halted_cnt_b", int'(o_cnt[1]), 4);
    adv();
    for (int i = 0; i < 9; i++) tick();
    cyc();
    chk("halt_idle_cnt_a", int'(o_cnt[0]), 2);
    chk("halt_idle_cnt_b", int'(o_cnt[1]), 4);
    adv();
    resume = 1;
    tick();
    idle();
    cyc();
    chk("resumed_a", int'(o_vec[0]), int'(V_NORM));
    chk("resumed_b", int'(o_vec[1]), int'(V_NORM));
    adv();

    // Reset abandons a STALL sequence mid-flight.
    set_hazard();
    tick();
    idle();
    reset = 1'b0;
    #1;
    chk("async_rst_vec_b", int'(o_vec[1]), int'(V_RST));
    chk("async_rst_cnt_b", int'(o_cnt[1]), 0);
    chk("async_rst_cnt_a", int'(o_cnt[0]), 0);
    model_clear();
    tick();
    reset = 1'b1;
    cyc();
    chk("post_rst_b", int'(o_vec[1]), int'(V_NORM));
    chk("post_rst_a", int'(o_vec[0]), int'(V_NORM));
    adv();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      dec_ra      = 2'($urandom_range(0, 3));
      dec_rb      = 2'($urandom_range(0, 3));
      ex_rd       = 2'($urandom_range(0, 3));
      dec_use_ra  = 1'($urandom_range(0, 1));
      dec_use_rb  = 1'($urandom_range(0, 1));
      ex_RW       = ($urandom_range(0, 3) != 0);
      ex_load     = ($urandom_range(0, 2) != 0);
      ex_br_taken = ($urandom_range(0, 5) == 0);
      ex_Hlt      = ($urandom_range(0, 19) == 0);
      resume      = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 249) != 0);
      if (!reset) model_clear();
      tick();
    end

    // Saturation: 300 consecutive hazard cycles from a clean start.
    idle();
    reset = 1'b0;
    model_clear();
    tick();
    reset = 1'b1;
    set_hazard();
    for (int i = 0; i < 300; i++) tick();
    idle();
    cyc();
    chk("sat_cnt_a", int'(o_cnt[0]), 255);
    chk("sat_cnt_b", int'(o_cnt[1]), 255);
    adv();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter LOAD_LAT, default 1, number of bubbles inserted per load-use hazard; legal range 1..3.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-low.
REQ-004 dec_ra, dec_rb  in  2 each  source register fields of the instruction in Decode.
REQ-005 dec_use_ra, dec_use_rb  in  1 each  Decode instruction actually reads ra / rb.
REQ-006 ex_rd  in  2  destination register of the instruction in Execute.
REQ-007 ex_RW, ex_load  in  1 each  Execute instruction writes a register / takes that value from memory.
REQ-008 ex_br_taken  in  1  branch unit resolved taken in Execute this cycle.
REQ-009 ex_Hlt  in  1  Execute instruction is HLT.
REQ-010 resume  in  1  single-cycle pulse releasing HALT.
REQ-011 pc_ld, f_d_ld, d_ex_ld  out  1 each  load enables for PC, F/D latch and D/Ex latch.
REQ-012 f_d_flush, d_ex_flush  out  1 each  flush requests to F/D and D/Ex latches; flush wins over ld in the latches.
REQ-013 halted  out  1  core is in HALT.
REQ-014 stall_cnt  out  8  saturating count of stall cycles.

Function
REQ-015 State register SHALL hold one of RUN, STALL, HALT; bubble counter bub (2 bits).
REQ-016 Outputs SHALL be Mealy: combinational from state and current inputs, so that stall/flush act in the cycle the event is detected.
REQ-017 hazard SHALL equal ex_load & ex_RW & ((dec_use_ra & dec_ra==ex_rd) | (dec_use_rb & dec_rb==ex_rd)).
REQ-018 RUN priority SHALL be ex_Hlt > ex_br_taken > hazard > normal.
REQ-019 RUN normal: pc_ld=f_d_ld=d_ex_ld=1, flushes=0, next RUN.
REQ-020 RUN ex_Hlt: pc_ld=0, f_d_ld=0, f_d_flush=1, d_ex_flush=1, next HALT.
REQ-021 RUN ex_br_taken (no Hlt): pc_ld=1 (target), f_d_flush=1, d_ex_flush=1, next RUN; concurrent hazard ignored.
REQ-022 RUN hazard only: pc_ld=0, f_d_ld=0, d_ex_flush=1; if LOAD_LAT=1 next RUN, else next STALL with bub=LOAD_LAT-1.
REQ-023 STALL: pc_ld=0, f_d_ld=0, d_ex_flush=1; ex_br_taken, ex_Hlt, hazard ignored (Execute holds a bubble); bub decrements; bub==1 -> next RUN.
REQ-024 HALT: all ld=0, all flush=0, halted=1; resume=1 -> next RUN; resume in any other state ignored.
REQ-025 stall_cnt SHALL increment by 1 each cycle pc_ld=0 in RUN or STALL (HALT excluded) and saturate at 255.
REQ-026 d_ex_ld SHALL be 1 in RUN and STALL (flush dominates), 0 in HALT.

Reset
REQ-027 reset=0 SHALL immediately force state RUN, bub=0, stall_cnt=0, halted=0.
REQ-028 While reset=0, pc_ld, f_d_ld, d_ex_ld, f_d_flush, d_ex_flush SHALL all be 0.
REQ-029 Reset asserted mid-STALL or in HALT SHALL abandon the sequence; first cycle after release is RUN normal.

Verification
REQ-030 LOAD_LAT=1, ex_load=ex_RW=1, ex_rd=2, dec_ra=2, dec_use_ra=1 -> that cycle pc_ld=0, f_d_ld=0, d_ex_flush=1; next cycle (hazard cleared) all ld=1; stall_cnt=1.
REQ-031 LOAD_LAT=3, same hazard held 1 cycle -> pc_ld=0 for exactly 3 consecutive cycles, ex_br_taken=1 pulsed in cycle 2 ignored, stall_cnt=3.
REQ-032 ex_br_taken=1 with hazard=1 same cycle -> pc_ld=1, f_d_flush=1, d_ex_flush=1, no stall next cycle, stall_cnt unchanged.
REQ-033 ex_Hlt=1 and ex_br_taken=1 same cycle -> pc_ld=0, both flushes=1; next cycle halted=1, all ld=0; 10 idle cycles stall_cnt unchanged; resume pulse -> next cycle halted=0, all ld=1.
REQ-034 Force 300 hazard cycles -> stall_cnt holds 255, no wrap.
REQ-035 reset=0 asynchronously during STALL (LOAD_LAT=3, bub=2) -> outputs 0 immediately, stall_cnt=0; after release RUN normal, all ld=1.
